// File: rtl/uc_pilha_seq_if.sv
// Request/status bundle between a stack user and the uc_pilha_seq pointer controller.
// The master drives requests. The slave (controller) returns addresses and status.
interface uc_pilha_seq_if #(
  parameter int W     = 32,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          PilhaE;
  logic          PilhaOP;
  logic          clr_erro;
  logic [W-1:0]  rp_out;
  logic [W-1:0]  rp_mem;
  logic          mem_we;
  logic [CW-1:0] count;
  logic          cheia;
  logic          vazia;
  logic          erro;

  modport master (
    output PilhaE, PilhaOP, clr_erro,
    input  rp_out, rp_mem, mem_we, count, cheia, vazia, erro
  );

  modport slave (
    input  PilhaE, PilhaOP, clr_erro,
    output rp_out, rp_mem, mem_we, count, cheia, vazia, erro
  );
endinterface

// File: rtl/uc_pilha_seq.sv
// uc_pilha_seq: stack-pointer and occupancy controller for a memory-backed LIFO.
// Define UC_PILHA_PROT_EN to enable overflow/underflow detection and the ERRO state.
module uc_pilha_seq #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int BASE  = 0
) (
  input  logic          clock,
  input  logic          reset,
  uc_pilha_seq_if.slave bus
);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [W-1:0]  ONE_W   = W'(1);
  localparam logic [W-1:0]  RP_RST  = W'(BASE) - ONE_W;
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  typedef enum logic {OK, ERRO} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  rp_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc, cnt_dec;
  logic          full, empty;
  logic          req, fault, push_ok, pop_ok;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    full    = (cnt_q == CNT_MAX);
    empty   = (cnt_q == '0);
    // An op presented in the reset cycle is discarded, so it can neither commit nor fault.
    req     = bus.PilhaE && !reset;
`ifdef UC_PILHA_PROT_EN
    fault   = req && (bus.PilhaOP ? full : empty);
`else
    fault   = 1'b0;
`endif
    push_ok = req && (state == OK) && !fault && bus.PilhaOP;
    pop_ok  = req && (state == OK) && !fault && !bus.PilhaOP;
    // Occupancy wraps modulo DEPTH+1 when protection is absent.
    cnt_inc = full  ? '0      : cnt_q + ONE_C;
    cnt_dec = empty ? CNT_MAX : cnt_q - ONE_C;
  end

  // A fault in the same cycle as clr_erro keeps the FSM in ERRO.
  always_comb begin
    state_nx = state;
    case (state)
      OK:      if (fault) state_nx = ERRO;
      ERRO:    if (!fault && bus.clr_erro) state_nx = OK;
      default: state_nx = OK;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= OK;
      rp_q  <= RP_RST;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      if (push_ok) begin
        rp_q  <= rp_q + ONE_W;
        cnt_q <= cnt_inc;
      end else if (pop_ok) begin
        rp_q  <= rp_q - ONE_W;
        cnt_q <= cnt_dec;
      end
    end
  end

`ifdef UC_PILHA_PROT_EN
  logic erro_q;

  always_ff @(posedge clock) begin
    if (reset) erro_q <= 1'b0;
    else       erro_q <= (state_nx == ERRO);
  end

  assign bus.erro = erro_q;
`else
  assign bus.erro = 1'b0;
`endif

  // A push writes one slot above the current top; a pop reads the top itself.
  assign bus.rp_mem = push_ok ? rp_q + ONE_W : rp_q;
  assign bus.mem_we = push_ok;
  assign bus.rp_out = rp_q;
  assign bus.count  = cnt_q;
  assign bus.cheia  = full;
  assign bus.vazia  = empty;
endmodule

// File: tb/tb_uc_pilha_seq.sv
// Scoreboard bench for uc_pilha_seq: default instance (W=32, BASE=0) and a W=8, BASE=100 instance.
// The driver queues hand-computed expectations. The monitor compares them against the DUT every tracked cycle.
module tb_uc_pilha_seq;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  uc_pilha_seq_if #(.W(32), .DEPTH(16)) ifa ();
  uc_pilha_seq_if #(.W(8),  .DEPTH(16)) ifb ();

  uc_pilha_seq #(.W(32), .DEPTH(16), .BASE(0))   dut_a (.clock(clk), .reset(rst_a), .bus(ifa));
  uc_pilha_seq #(.W(8),  .DEPTH(16), .BASE(100)) dut_b (.clock(clk), .reset(rst_b), .bus(ifb));

  // Expected view of one cycle: outputs seen before the edge that commits the op.
  typedef struct {
    bit          sel;
    logic [31:0] mem;
    bit          we;
    logic [31:0] rp;
    int          cnt;
    bit          erro;
  } exp_t;

  exp_t sb[$];
  bit   mon_v = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_all();
    ifa.PilhaE = 1'b0; ifa.PilhaOP = 1'b0; ifa.clr_erro = 1'b0;
    ifb.PilhaE = 1'b0; ifb.PilhaOP = 1'b0; ifb.clr_erro = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
  endtask

  task automatic drive_idle();
    @(negedge clk);
    idle_all();
    mon_v = 1'b0;
  endtask

  task automatic step(input bit sel, input bit pe, input bit op, input bit clr, input bit rs,
                      input logic [31:0] e_mem, input bit e_we, input logic [31:0] e_rp,
                      input int e_cnt, input bit e_erro);
    exp_t e;
    @(negedge clk);
    idle_all();
    if (sel) begin
      ifb.PilhaE = pe; ifb.PilhaOP = op; ifb.clr_erro = clr; rst_b = rs;
    end else begin
      ifa.PilhaE = pe; ifa.PilhaOP = op; ifa.clr_erro = clr; rst_a = rs;
    end
    e.sel = sel; e.mem = e_mem; e.we = e_we; e.rp = e_rp; e.cnt = e_cnt; e.erro = e_erro;
    sb.push_back(e);
    mon_v = 1'b1;
  endtask

  // Monitor: samples two time units after the driver changes inputs, well before the next rising edge.
  initial begin
    int idx = 0;
    forever begin
      @(negedge clk);
      #2;
      if (mon_v) begin
        exp_t e;
        logic [31:0] a_mem, a_rp, a_cnt;
        logic a_we, a_cheia, a_vazia, a_erro;
        if (sb.size() == 0) begin
          check($sformatf("%0d.sb_empty", idx), 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          if (e.sel) begin
            a_mem = {24'd0, ifb.rp_mem}; a_rp = {24'd0, ifb.rp_out}; a_cnt = {27'd0, ifb.count};
            a_we = ifb.mem_we; a_cheia = ifb.cheia; a_vazia = ifb.vazia; a_erro = ifb.erro;
          end else begin
            a_mem = ifa.rp_mem; a_rp = ifa.rp_out; a_cnt = {27'd0, ifa.count};
            a_we = ifa.mem_we; a_cheia = ifa.cheia; a_vazia = ifa.vazia; a_erro = ifa.erro;
          end
          check($sformatf("%0d.rp_mem", idx), a_mem, e.mem);
          check($sformatf("%0d.mem_we", idx), {31'd0, a_we}, {31'd0, e.we});
          check($sformatf("%0d.rp_out", idx), a_rp, e.rp);
          check($sformatf("%0d.count", idx), a_cnt, 32'(e.cnt));
          check($sformatf("%0d.cheia", idx), {31'd0, a_cheia}, {31'd0, e.cnt == 16});
          check($sformatf("%0d.vazia", idx), {31'd0, a_vazia}, {31'd0, e.cnt == 0});
          check($sformatf("%0d.erro", idx), {31'd0, a_erro}, {31'd0, e.erro});
        end
        idx++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  localparam logic [31:0] M1 = 32'hFFFF_FFFF;

  initial begin
    idle_all();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(posedge clk);

    //   sel pe op clr rs  rp_mem      we  rp_out      cnt erro
    step(0, 0, 0, 0, 0, M1,          0, M1,          0,  0);  // reset state
    step(0, 1, 1, 0, 0, 32'd0,       1, M1,          0,  0);
    step(0, 1, 1, 0, 0, 32'd1,       1, 32'd0,       1,  0);
    step(0, 1, 1, 0, 0, 32'd2,       1, 32'd1,       2,  0);
    step(0, 1, 0, 0, 0, 32'd2,       0, 32'd2,       3,  0);  // pop right after push
    step(0, 1, 0, 0, 0, 32'd1,       0, 32'd1,       2,  0);
    step(0, 1, 0, 0, 0, 32'd0,       0, 32'd0,       1,  0);
    step(0, 0, 0, 1, 0, M1,          0, M1,          0,  0);  // clr_erro in OK
    step(0, 0, 0, 0, 0, M1,          0, M1,          0,  0);

    // Five pushes, then a push coinciding with reset.
    step(0, 1, 1, 0, 0, 32'd0,       1, M1,          0,  0);
    step(0, 1, 1, 0, 0, 32'd1,       1, 32'd0,       1,  0);
    step(0, 1, 1, 0, 0, 32'd2,       1, 32'd1,       2,  0);
    step(0, 1, 1, 0, 0, 32'd3,       1, 32'd2,       3,  0);
    step(0, 1, 1, 0, 0, 32'd4,       1, 32'd3,       4,  0);
    step(0, 1, 1, 0, 1, 32'd4,       0, 32'd4,       5,  0);
    step(0, 0, 0, 0, 0, M1,          0, M1,          0,  0);

`ifdef UC_PILHA_PROT_EN
    // Underflow, then clr_erro together with another faulting pop.
    step(0, 1, 0, 0, 0, M1,          0, M1,          0,  0);
    step(0, 1, 0, 1, 0, M1,          0, M1,          0,  1);
    step(0, 0, 0, 1, 0, M1,          0, M1,          0,  1);
    step(0, 0, 0, 0, 0, M1,          0, M1,          0,  0);
    // Fill to DEPTH, then overflow.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      a = 32'(i);
      step(0, 1, 1, 0, 0, a,         1, a - 32'd1,   i,  0);
    end
    step(0, 1, 1, 0, 0, 32'd15,      0, 32'd15,      16, 0);
    step(0, 1, 1, 0, 0, 32'd15,      0, 32'd15,      16, 1);  // ignored in ERRO
    step(0, 0, 0, 1, 0, 32'd15,      0, 32'd15,      16, 1);
    step(0, 1, 0, 0, 0, 32'd15,      0, 32'd15,      16, 0);
    step(0, 0, 0, 0, 0, 32'd14,      0, 32'd14,      15, 0);
`else
    // Unprotected: pop at empty and push at full both wrap.
    step(0, 1, 0, 0, 0, M1,          0, M1,          0,  0);
    step(0, 0, 0, 0, 0, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 16, 0);
    step(0, 1, 1, 0, 0, M1,          1, 32'hFFFF_FFFE, 16, 0);
    step(0, 0, 0, 0, 0, M1,          0, M1,          0,  0);
`endif

    // W=8, BASE=100 instance.
    step(1, 0, 0, 0, 0, 32'd99,      0, 32'd99,      0,  0);
    step(1, 1, 1, 0, 0, 32'd100,     1, 32'd99,      0,  0);
    step(1, 1, 1, 0, 0, 32'd101,     1, 32'd100,     1,  0);
    step(1, 1, 0, 0, 0, 32'd101,     0, 32'd101,     2,  0);
    step(1, 1, 1, 0, 0, 32'd101,     1, 32'd100,     1,  0);
    step(1, 0, 0, 0, 0, 32'd101,     0, 32'd101,     2,  0);

    drive_idle();
    drive_idle();
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uc_pilha_seq.md
UC_PILHA_SEQ -- requirements
Module: uc_pilha_seq

Interface
REQ-001 Parameter: W, 32, width of stack pointer and memory address.
REQ-002 Parameter: DEPTH, 16, maximum number of stacked words (2..2^W-1).
REQ-003 Parameter: BASE, 0, memory address of the first (bottom) stack slot.
REQ-004 Port: clock  in  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: PilhaE  in  1  operation request, sampled each rising edge.
REQ-007 Port: PilhaOP  in  1  1 = push, 0 = pop (when PilhaE=1).
REQ-008 Port: clr_erro  in  1  clears error state.
REQ-009 Port: rp_out  out  W  registered stack pointer (address of top element).
REQ-010 Port: rp_mem  out  W  combinational memory address for the current-cycle operation.
REQ-011 Port: mem_we  out  1  combinational write strobe; 1 for an accepted push.
REQ-012 Port: count  out  $clog2(DEPTH+1)  registered number of stacked words.
REQ-013 Port: cheia / vazia  out  1 each  full (count==DEPTH) / empty (count==0), decoded from count.
REQ-014 Port: erro  out  1  registered, high while in state ERRO.

Function
REQ-015 Two-state FSM: OK, ERRO; an operation is accepted only in OK with PilhaE=1 and no fault.
REQ-016 Accepted push: rp_mem = rp_out+1, mem_we=1; next edge rp_out <= rp_out+1, count <= count+1.
REQ-017 Accepted pop: rp_mem = rp_out, mem_we=0; next edge rp_out <= rp_out-1, count <= count-1.
REQ-018 PilhaE=0, or state ERRO: rp_mem = rp_out, mem_we=0, rp_out and count hold.
REQ-019 Pointer arithmetic modulo 2^W; no other width extension.
REQ-020 Push accepted one cycle, pop next cycle: pop rp_mem equals address just written (zero-bubble back-to-back).
REQ-021 Fault conditions (with protection compiled in): push while cheia = overflow; pop while vazia = underflow.
REQ-022 On fault: operation rejected (mem_we=0, rp_out/count hold), FSM OK -> ERRO at next edge.
REQ-023 ERRO -> OK only on clr_erro=1 at an edge; rp_out/count preserved across ERRO.
REQ-024 clr_erro=1 in OK: no effect; clr_erro and a faulting op in the same cycle: fault wins, ERRO entered.
REQ-025 Single outstanding op per cycle; no other handshake; every accepted op completes in one cycle.

Reset
REQ-026 On reset=1 at an edge: rp_out <= BASE-1 (mod 2^W), count <= 0, FSM <= OK, erro <= 0.
REQ-027 reset takes priority over PilhaE and clr_erro in the same cycle; an op during the reset cycle is discarded.
REQ-028 During the reset cycle mem_we SHALL be 0.

Configuration
REQ-029 Macro UC_PILHA_PROT_EN: when defined, overflow/underflow detection and ERRO state per REQ-021..024.
REQ-030 Without UC_PILHA_PROT_EN: no fault detection, erro tied 0, FSM stays OK, push at full/pop at empty accepted; rp_out wraps modulo 2^W and count wraps modulo DEPTH+1.

Verification
REQ-031 Reset then 3 pushes (defaults) -> rp_mem 0,1,2 with mem_we=1; final rp_out=2, count=3, vazia=0.
REQ-032 After REQ-031, 3 pops -> rp_mem 2,1,0, mem_we=0; final rp_out=32'hFFFFFFFF, count=0, vazia=1.
REQ-033 PROT on, DEPTH=16: 16 pushes -> cheia=1, rp_out=15; 17th push -> mem_we=0, rp_out=15, erro=1 next cycle; pushes ignored until clr_erro, then erro=0.
REQ-034 PROT on: pop from empty after reset -> mem_we=0, rp_out=32'hFFFFFFFF, erro=1; clr_erro together with a second pop -> erro stays 1.
REQ-035 Push accepted with reset=1 in same cycle after 5 pushes -> rp_out=BASE-1, count=0, mem_we=0.
REQ-036 BASE=100, W=8: push,push,pop,push -> rp_mem 100,101,101,101; final rp_out=101, count=2.
